// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer.
// No logic; widths and field offsets of a queued command entry.
// Not applicable (no flow control here).
package i2c_seq_pkg;

    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 16;
    localparam int CMD_W         = 1 + ADDR_W + DATA_W;
    localparam int CMD_WDATA_LSB = 0;
    localparam int CMD_ADDR_LSB  = CMD_WDATA_LSB + DATA_W;
    localparam int CMD_RNW_BIT   = CMD_ADDR_LSB + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_XFER   = 2'd2,
        ST_RESP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries, combinational head read.
// Write visible at dout one cycle after push; pop takes effect at the edge.
// full is registered-state based; push while full and pop while empty are dropped.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and launches them one at a time to the master, one response each.
// Push to START_STB: 2 edges when idle; STOP detect to RSP_VALID: 1 cycle; RESP to next START_STB: 2 cycles.
// CMD_READY = FIFO not full; responses are a one-cycle strobe with no backpressure.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2048,
    parameter int CNT_W       = 12,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_RNW,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic              RSP_RNW,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_TIMEOUT,
    output logic              BUSY,
    output logic [LVL_W-1:0]  LEVEL,
    output logic              START_STB,
    output logic              RNW,
    output logic [ADDR_W-1:0] I2C_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic [DATA_W-1:0] RD_DATA,
    input  logic              SCL,
    input  logic              SDA
);

    seq_state_t        state, state_nxt;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              scl_q;
    logic              sda_q;
    logic              start_det;
    logic              stop_det;
    logic [CNT_W-1:0]  timer;
    logic              timer_exp;
    logic              rsp_load;
    logic              rsp_tmo_nxt;
    logic              start_stb_c;
    logic              busy_c;
    logic              rsp_vld_c;

    assign fifo_din  = {CMD_RNW, CMD_ADDR, CMD_WDATA};
    assign CMD_READY = !fifo_full;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (CMD_VALID),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL)
    );

    // Bus history: one-cycle delayed SCL/SDA, reset to the idle-high bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= SCL;
            sda_q <= SDA;
        end
    end

    // SDA edges only count while SCL is high on both samples.
    assign start_det = sda_q && !SDA && scl_q && SCL;
    assign stop_det  = !sda_q && SDA && scl_q && SCL;
    assign timer_exp = (timer == CNT_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; STOP in LAUNCH and START in XFER fall through unused.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        start_stb_c = 1'b0;
        busy_c      = 1'b0;
        rsp_vld_c   = 1'b0;
        rsp_load    = 1'b0;
        rsp_tmo_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                start_stb_c = 1'b1;
                busy_c      = 1'b1;
                if (start_det) begin
                    state_nxt = ST_XFER;
                end else if (timer_exp) begin
                    state_nxt   = ST_RESP;
                    rsp_load    = 1'b1;
                    rsp_tmo_nxt = 1'b1;
                end
            end
            ST_XFER: begin
                busy_c = 1'b1;
                if (stop_det) begin
                    state_nxt = ST_RESP;
                    rsp_load  = 1'b1;
                end else if (timer_exp) begin
                    state_nxt   = ST_RESP;
                    rsp_load    = 1'b1;
                    rsp_tmo_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_vld_c = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign START_STB = start_stb_c;
    assign BUSY      = busy_c;
    assign RSP_VALID = rsp_vld_c;

    // Timeout counter: cleared on the pop into LAUNCH, saturates at all-ones.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            timer <= '0;
        end else if (pop) begin
            timer <= '0;
        end else if ((state == ST_LAUNCH || state == ST_XFER) && (timer != '1)) begin
            timer <= timer + CNT_W'(1);
        end
    end

    // Master-facing command registers; held stable until the next pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RNW      <= 1'b0;
            I2C_ADDR <= '0;
            WR_DATA  <= '0;
        end else if (pop) begin
            RNW      <= fifo_dout[CMD_RNW_BIT];
            I2C_ADDR <= fifo_dout[CMD_ADDR_LSB +: ADDR_W];
            WR_DATA  <= fifo_dout[CMD_WDATA_LSB +: DATA_W];
        end
    end

    // Response fields latched on entry to RESP and held until the next response.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RSP_RNW     <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_TIMEOUT <= 1'b0;
        end else if (rsp_load) begin
            RSP_RNW     <= RNW;
            RSP_TIMEOUT <= rsp_tmo_nxt;
            RSP_RDATA   <= (RNW && !rsp_tmo_nxt) ? RD_DATA : '0;
        end
    end

endmodule
